// File: rtl/tff_mod_counter.sv
// tff_mod_counter
//
// Parametrised up/down modulo counter built from WIDTH toggle stages.
// The count runs from zero up to one below the modulus. The counter
// supports hold, count up, count down and a saturating parallel load.
// It provides a combinational terminal-count flag and a registered
// one-cycle wrap pulse.
module tff_mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             clr_bar,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  mode_e            mode_s;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_zero;

  assign mode_s  = mode_e'(mode);
  assign at_max  = (Q == MAX_CNT);
  assign at_zero = (Q == '0);

  // Target value for the next edge; it reaches the register only through
  // the per-bit toggle enables below.
  always_comb begin
    next_q = Q;
    case (mode_s)
      MODE_HOLD: next_q = Q;
      MODE_UP: begin
        if (en) begin
          next_q = at_max ? '0 : (Q + ONE);
        end
      end
      MODE_DOWN: begin
        if (en) begin
          next_q = at_zero ? MAX_CNT : (Q - ONE);
        end
      end
      MODE_LOAD: next_q = (d > MAX_CNT) ? MAX_CNT : d;
      default:   next_q = Q;
    endcase
  end

  // A bit toggles exactly where the target value differs from the current one.
  assign t = Q ^ next_q;

  // The terminal-count condition is the same condition that makes the edge
  // wrap, so the registered wrap flag is simply tc sampled on the edge.
  assign tc = en & (((mode_s == MODE_UP) & at_max) |
                    ((mode_s == MODE_DOWN) & at_zero));

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (t[i]) begin
          Q[i] <= ~Q[i];
        end
      end
      wrap <= tc;
    end
  end

  assign Qbar = ~Q;

endmodule

// File: doc/tff_mod_counter.md
# tff_mod_counter

Parametrised synchronous up/down counter built from toggle (T) flip-flop stages. It generalises the single-bit T flip-flop to a WIDTH-bit register with programmable modulus, count direction, parallel load, hold, terminal-count detection and a registered wrap pulse. It is the counting element for the lab's sequential datapath blocks, including dividers, sequencers and timers, and replaces hand-chained single T flip-flops.

## Interface
- WIDTH, default 4, counter width in bits; legal range 1..16.
- MOD, default 16, count modulus; legal range 2..2^WIDTH. The count runs 0..MOD-1.
- clk  input  1  clock; all state updates occur on the rising edge.
- clr_bar  input  1  reset, asynchronous and active-low. Clears all state immediately.
- en  input  1  count enable. When low, Q holds for every mode except load.
- mode  input  2  00 hold, 01 count up, 10 count down, 11 parallel load.
- d  input  WIDTH  parallel load value.
- Q  output  WIDTH  current count.
- Qbar  output  WIDTH  bitwise complement of Q, always valid including during reset.
- tc  output  1  terminal count, combinational. High when the next enabled edge will wrap.
- wrap  output  1  registered pulse. High for exactly one cycle after an edge that wrapped the count.

## Operation
- State register: WIDTH toggle stages. Each bit i has a toggle enable t[i] = Q[i] XOR next[i]. The implementation computes next per the rules below and applies it only through these per-bit toggles.
- hold (00), or en=0 with mode≠11: next = Q. All t[i] = 0. wrap is cleared to 0 on this edge.
- up (01, en=1):
  - If Q = MOD-1, next = 0 and wrap is set to 1.
  - Otherwise next = Q+1 and wrap is set to 0.
- down (10, en=1):
  - If Q = 0, next = MOD-1 and wrap is set to 1.
  - Otherwise next = Q-1 and wrap is set to 0.
- load (11): acts regardless of en.
  - next = d if d ≤ MOD-1; otherwise next = MOD-1 (saturate).
  - wrap is set to 0.
- tc = en AND ((mode=01 AND Q=MOD-1) OR (mode=10 AND Q=0)). tc is 0 in hold and load.
- Out-of-range state (Q ≥ MOD) cannot occur; reset and load both keep Q < MOD.
- Arithmetic:
  - Comparisons are unsigned, WIDTH bits.
  - MOD-1 is held as a WIDTH-bit constant.
  - When MOD = 2^WIDTH, wrap-around follows natural binary rollover with identical tc and wrap behaviour.

## Timing
- Reset (clr_bar=0) acts asynchronously, with no clock needed: Q=0, Qbar=all ones, wrap=0, tc follows the combinational rule with Q=0.
- Reset asserted mid-count abandons the count immediately. The value present before reset is not retained.
- Reset release: the first rising edge with clr_bar=1 is the first functional edge. Release coincident with a clock edge must not produce a partial update; Q stays 0 on that edge.
- Latency: Q reflects mode, en and d one edge after they are sampled.
- wrap asserts on the same edge that Q wraps and lasts exactly one cycle unless the next edge wraps again. With MOD=2 counting up continuously, wrap is high on every other cycle.
- tc is valid in the same cycle as Q and is combinational from Q, mode and en. The combinational path is tc → wrap on the following edge.
- Direction change mid-count takes effect on the next edge, with no extra cycle.
- Simultaneous events:
  - load with en=0 still loads.
  - Load of a value equal to MOD-1 while mode was up does not raise wrap.

## Test plan
- Reset and basic count: WIDTH=4, MOD=10; assert clr_bar low, release, then up with en=1 for 12 edges. Required: Q sequence 0,1,…,9,0,1,2; tc high only while Q=9; wrap high for exactly the cycle after Q returns to 0.
- Down wrap: MOD=10, load d=2, then down for 4 edges. Required: Q 2,1,0,9,8; tc high only at Q=0; one wrap pulse at Q=9.
- Load saturation and en independence: MOD=10, en=0, mode=11, d=13. Required: Q=9 after one edge, wrap=0. Then d=5 gives Q=5.
- Hold and enable gating: at Q=7, mode=01 with en=0 for 3 edges, then mode=00 with en=1 for 3 edges. Required: Q stays 7 throughout and tc=0.
- Asynchronous reset mid-operation: counting up at Q=6, pull clr_bar low between edges. Required: Q=0, Qbar=4'b1111 and wrap=0 before the next edge. Counting resumes 1,2 after release.
- Full-range rollover: WIDTH=3, MOD=8, count up from 6. Required: Q 6,7,0,1; tc at 7; single wrap pulse. Qbar equals ~Q on every cycle.
